ring_buffer_arbiter: RTL

- Round-robin, packet-locked arbiter that drains N_PORTS RingBuffer outputs into one shared downstream RingBuffer input.
- Each packet is one header flit followed by the number of payload flits given in the header's length field.
- Once a port is granted, the grant is held until that port's whole packet has transferred, so packets are never interleaved.
- Sits between per-source ingress buffers and a shared egress buffer or link.

---
 rtl/ring_buffer_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ring_buffer_arbiter.sv
// Round-robin, packet-locked arbiter draining N_PORTS upstream ring buffers into one
// downstream buffer. A grant is held from the header flit through the last payload flit.
module ring_buffer_arbiter #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned LEN_SIZE  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         buf_rst_i,
    input  logic [N_PORTS-1:0]           tx_i,
    output logic [N_PORTS-1:0]           tx_ack_o,
    input  logic [N_PORTS*DATA_SIZE-1:0] data_i,
    output logic                         rx_o,
    input  logic                         rx_ack_i,
    output logic [DATA_SIZE-1:0]         data_o,
    output logic                         busy_o,
    output logic [$clog2(N_PORTS)-1:0]   grant_o,
    output logic [1:0]                   dbg_state
);

    localparam int unsigned GW = $clog2(N_PORTS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       g_q, g_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [LEN_SIZE-1:0] cnt_q, cnt_d;
    logic [GW-1:0]       cand, pick, nxt_ptr;
    logic                found, xfer;
    logic [LEN_SIZE-1:0] len;
    logic [DATA_SIZE-1:0] flit [N_PORTS];

    for (genvar k = 0; k < N_PORTS; k++) begin : g_slice
        assign flit[k] = data_i[k*DATA_SIZE +: DATA_SIZE];
    end

    // Handshake: rx_o is valid, rx_ack_i is ready (independent of rx_o); a flit moves
    // when both are high, and the same cycle pops the granted upstream via tx_ack_o.
    assign xfer      = (state_q != IDLE) && tx_i[g_q] && rx_ack_i;
    assign rx_o      = (state_q != IDLE) && tx_i[g_q];
    assign data_o    = flit[g_q];
    assign busy_o    = (state_q != IDLE);
    assign grant_o   = g_q;
    assign dbg_state = state_q;
    assign len       = data_o[LEN_SIZE-1:0];
    assign nxt_ptr   = (g_q == GW'(N_PORTS - 1)) ? '0 : g_q + GW'(1);

    always_comb begin
        tx_ack_o      = '0;
        tx_ack_o[g_q] = xfer;
    end

    // Search ptr, ptr+1, ... modulo N_PORTS; the port just served sits at the end.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cand = GW'((32'(ptr_q) + i) % N_PORTS);
            if (!found && tx_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d     = pick;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    if (len == '0) begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                    end else begin
                        cnt_d   = len;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - LEN_SIZE'(1);
                    if (cnt_q == LEN_SIZE'(1)) begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (buf_rst_i) begin
            state_q <= IDLE;
            g_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
